// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide, 1-cycle-read data RAM.
// Sub-word stores become read-modify-write; misaligned or illegal accesses fault without touching the RAM.
module load_store_unit #(
  parameter int unsigned ADDRWIDTH = 6,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iReq,
  input  logic                   iWE,
  input  logic [2:0]             iFunct3,
  input  logic [ADDRWIDTH+1:0]   iByteAddr,
  input  logic [DATAWIDTH-1:0]   iStoreData,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oFault,
  output logic [DATAWIDTH-1:0]   oLoadData,
  output logic                   oRamWR,
  output logic [ADDRWIDTH-1:0]   oRamAddr,
  output logic [DATAWIDTH-1:0]   oRamWData,
  input  logic [DATAWIDTH-1:0]   iRamRData
);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t                 state, state_d;
  logic                   we_q, we_d;
  logic [2:0]             f3_q, f3_d;
  logic [1:0]             lane_q, lane_d;
  logic [15:0]            sdata_q, sdata_d;
  logic                   done_d, fault_d, ram_wr_d;
  logic [DATAWIDTH-1:0]   load_d, wdata_d;
  logic [ADDRWIDTH-1:0]   ram_addr_d;
  logic                   req_fault_c;
  logic [7:0]             rd_byte;
  logic [15:0]            rd_half;
  logic [DATAWIDTH-1:0]   load_fmt;
  logic [DATAWIDTH-1:0]   merged;

  assign oBusy = (state != IDLE);

  // Illegal funct3 for the direction, or address not aligned to the access size
  always_comb begin
    if (iWE) req_fault_c = iFunct3[2] | (iFunct3[1:0] == 2'b11);
    else     req_fault_c = (iFunct3 == 3'b011) | (iFunct3[2:1] == 2'b11);
    if ((iFunct3[1:0] == 2'b01) && iByteAddr[0])          req_fault_c = 1'b1;
    if ((iFunct3[1:0] == 2'b10) && (iByteAddr[1:0] != 2'b00)) req_fault_c = 1'b1;
  end

  // Lane extraction for loads and lane insertion for sub-word stores
  always_comb begin
    case (lane_q)
      2'd1:    rd_byte = iRamRData[15:8];
      2'd2:    rd_byte = iRamRData[23:16];
      2'd3:    rd_byte = iRamRData[31:24];
      default: rd_byte = iRamRData[7:0];
    endcase
    rd_half = lane_q[1] ? iRamRData[31:16] : iRamRData[15:0];
    case (f3_q[1:0])
      2'b00:   load_fmt = {{24{rd_byte[7] & ~f3_q[2]}}, rd_byte};
      2'b01:   load_fmt = {{16{rd_half[15] & ~f3_q[2]}}, rd_half};
      default: load_fmt = iRamRData;
    endcase
    merged = iRamRData;
    if (f3_q[0]) begin
      if (lane_q[1]) merged[31:16] = sdata_q;
      else           merged[15:0]  = sdata_q;
    end else begin
      case (lane_q)
        2'd1:    merged[15:8]  = sdata_q[7:0];
        2'd2:    merged[23:16] = sdata_q[7:0];
        2'd3:    merged[31:24] = sdata_q[7:0];
        default: merged[7:0]   = sdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d    = state;
    we_d       = we_q;
    f3_d       = f3_q;
    lane_d     = lane_q;
    sdata_d    = sdata_q;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    ram_wr_d   = 1'b0;
    load_d     = oLoadData;
    wdata_d    = oRamWData;
    ram_addr_d = oRamAddr;
    case (state)
      IDLE: begin
        if (iReq) begin
          we_d    = iWE;
          f3_d    = iFunct3;
          lane_d  = iByteAddr[1:0];
          sdata_d = iStoreData[15:0];
          if (req_fault_c) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            ram_addr_d = iByteAddr[ADDRWIDTH+1:2];
            if (iWE && (iFunct3 == 3'b010)) begin
              ram_wr_d = 1'b1;
              wdata_d  = iStoreData;
              state_d  = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (we_q) begin
          wdata_d  = merged;
          ram_wr_d = 1'b1;
          state_d  = WR;
        end else begin
          load_d  = load_fmt;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= '0;
      lane_q    <= '0;
      sdata_q   <= '0;
      oDone     <= 1'b0;
      oFault    <= 1'b0;
      oLoadData <= '0;
      oRamWR    <= 1'b0;
      oRamAddr  <= '0;
      oRamWData <= '0;
    end else begin
      state     <= state_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
      sdata_q   <= sdata_d;
      oDone     <= done_d;
      oFault    <= fault_d;
      oLoadData <= load_d;
      oRamWR    <= ram_wr_d;
      oRamAddr  <= ram_addr_d;
      oRamWData <= wdata_d;
    end
  end

endmodule
